cast_gather_arbiter: RTL and testbench

// Packet-atomic weighted arbiter sharing one tile cast/gather injection port between two tile sources.

---
 rtl/cast_gather_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cast_gather_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cast_gather_arbiter.sv
// Packet-atomic weighted arbiter sharing one cast/gather injection port between the cast and gather sources.
// Define CG_ARB_SKID_EN to insert a registered 2-entry skid buffer on the output (+1 cycle latency).
//
// state  | meaning
// IDLE   | no packet owns the port; heads from both sources arbitrated each cycle
// LOCK_C | cast packet in flight; only cast flits forwarded
// LOCK_G | gather packet in flight; only gather flits forwarded
module cast_gather_arbiter #(
    parameter int DW          = 32,
    parameter int CAST_WEIGHT = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] cast_data_i,
    input  logic          cast_valid_i,
    output logic          cast_ready_o,
    input  logic [DW-1:0] gather_data_i,
    input  logic          gather_valid_i,
    output logic          gather_ready_o,
    output logic [DW-1:0] cast_gather_data_o,
    output logic          cast_gather_valid_o,
    input  logic          cast_gather_ready_i,
    output logic [1:0]    grant_o,
    output logic          err_o
);
    localparam int CW = $clog2(CAST_WEIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CAST_WEIGHT);
    localparam logic [1:0]    T_HEAD   = 2'b00;
    localparam logic [1:0]    T_TAIL   = 2'b10;
    localparam logic [1:0]    T_SINGLE = 2'b11;

    typedef enum logic [1:0] {IDLE, LOCK_C, LOCK_G} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          core_ready;
    logic          core_valid;
    logic [DW-1:0] core_data;
    logic          c_rdy, g_rdy, c_err, g_err, win_c, win_g;
    logic [1:0]    grant;

    wire [1:0] c_type    = cast_data_i[DW-1 -: 2];
    wire [1:0] g_type    = gather_data_i[DW-1 -: 2];
    wire [1:0] core_type = core_data[DW-1 -: 2];
    wire       c_head    = cast_valid_i && (c_type == T_HEAD || c_type == T_SINGLE);
    wire       g_head    = gather_valid_i && (g_type == T_HEAD || g_type == T_SINGLE);
    wire       core_xfer = core_valid && core_ready;
    wire       core_last = (core_type == T_TAIL) || (core_type == T_SINGLE);

    always_comb begin
        core_valid = 1'b0;
        core_data  = cast_data_i;
        c_rdy      = 1'b0;
        g_rdy      = 1'b0;
        c_err      = 1'b0;
        g_err      = 1'b0;
        win_c      = 1'b0;
        win_g      = 1'b0;
        grant      = 2'b00;
        case (state)
            IDLE: begin
                win_c      = c_head && (!g_head || cnt < CNT_MAX);
                win_g      = g_head && !win_c;
                // stray body/tail flits are swallowed so they cannot block the source
                c_err      = cast_valid_i && !c_head;
                g_err      = gather_valid_i && !g_head;
                core_valid = win_c || win_g;
                core_data  = win_g ? gather_data_i : cast_data_i;
                c_rdy      = win_c ? core_ready : c_err;
                g_rdy      = win_g ? core_ready : g_err;
                grant      = {win_g, win_c};
            end
            LOCK_C: begin
                core_valid = cast_valid_i;
                c_rdy      = core_ready;
                grant      = 2'b01;
            end
            LOCK_G: begin
                core_valid = gather_valid_i;
                core_data  = gather_data_i;
                g_rdy      = core_ready;
                grant      = 2'b10;
            end
            default: ;
        endcase
    end

    assign cast_ready_o   = rstn && c_rdy;
    assign gather_ready_o = rstn && g_rdy;
    assign grant_o        = rstn ? grant : 2'b00;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            if (c_err || g_err)
                err_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (win_c && g_head)
                        cnt <= cnt + CW'(1);
                    else if (win_g)
                        cnt <= '0;
                    if ((win_c || win_g) && !(core_xfer && core_type == T_SINGLE))
                        state <= win_c ? LOCK_C : LOCK_G;
                end
                LOCK_C, LOCK_G: begin
                    if (core_xfer && core_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CG_ARB_SKID_EN
    logic [DW-1:0] skid_mem [2];
    logic          skid_wr, skid_rd;
    logic [1:0]    skid_cnt;

    wire skid_push = core_valid && core_ready;
    wire skid_pop  = (skid_cnt != 2'd0) && cast_gather_ready_i;

    // core sees only buffer space, which breaks the ready_i -> ready_o path
    assign core_ready = (skid_cnt != 2'd2);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            skid_wr     <= 1'b0;
            skid_rd     <= 1'b0;
            skid_cnt    <= 2'd0;
        end else begin
            if (skid_push) begin
                skid_mem[skid_wr] <= core_data;
                skid_wr           <= ~skid_wr;
            end
            if (skid_pop)
                skid_rd <= ~skid_rd;
            case ({skid_push, skid_pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    assign cast_gather_valid_o = rstn && (skid_cnt != 2'd0);
    assign cast_gather_data_o  = skid_mem[skid_rd];
`else
    assign core_ready          = cast_gather_ready_i;
    assign cast_gather_valid_o = rstn && core_valid;
    assign cast_gather_data_o  = core_data;
`endif

endmodule

// File: tb/tb_cast_gather_arbiter.sv
// Randomized bench for cast_gather_arbiter: queue-based reference model plus directed literal checks.
module tb_cast_gather_arbiter;
    localparam int DW = 32;
    localparam int W  = 2;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] cast_data_i, gather_data_i, cast_gather_data_o;
    logic          cast_valid_i, cast_ready_o, gather_valid_i, gather_ready_o;
    logic          cast_gather_valid_o, cast_gather_ready_i, err_o;
    logic [1:0]    grant_o;

    cast_gather_arbiter #(.DW(DW), .CAST_WEIGHT(W)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .cast_data_i         (cast_data_i),
        .cast_valid_i        (cast_valid_i),
        .cast_ready_o        (cast_ready_o),
        .gather_data_i       (gather_data_i),
        .gather_valid_i      (gather_valid_i),
        .gather_ready_o      (gather_ready_o),
        .cast_gather_data_o  (cast_gather_data_o),
        .cast_gather_valid_o (cast_gather_valid_o),
        .cast_gather_ready_i (cast_gather_ready_i),
        .grant_o             (grant_o),
        .err_o               (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner of the port, contention counter, sticky error, output buffer queue
    int          m_owner = 0;   // 0 none, 1 cast, 2 gather
    int          m_cnt   = 0;
    bit          m_err   = 0;
    logic [31:0] m_q[$];

    always @(negedge clk) begin : ref_model
        bit          cr, ce, ge, cerr, gerr, ev, ecr, egr, outv;
        int          win, src;
        logic [31:0] ed;
        logic [1:0]  eg;
        chk("err_o", 32'(err_o), 32'(m_err));
`ifdef CG_ARB_SKID_EN
        cr = (m_q.size() < 2);
`else
        cr = cast_gather_ready_i;
`endif
        if (!rstn) begin
            chk("rst_valid_o", 32'(cast_gather_valid_o), 0);
            chk("rst_cast_ready", 32'(cast_ready_o), 0);
            chk("rst_gather_ready", 32'(gather_ready_o), 0);
            m_owner = 0;
            m_cnt   = 0;
            m_err   = 0;
            m_q.delete();
        end else begin
            ce   = cast_valid_i && (cast_data_i[31:30] == 2'b00 || cast_data_i[31:30] == 2'b11);
            ge   = gather_valid_i && (gather_data_i[31:30] == 2'b00 || gather_data_i[31:30] == 2'b11);
            cerr = (m_owner == 0) && cast_valid_i && !ce;
            gerr = (m_owner == 0) && gather_valid_i && !ge;
            win  = 0;
            if (m_owner == 0) begin
                if (ce && ge) win = (m_cnt < W) ? 1 : 2;
                else if (ce)  win = 1;
                else if (ge)  win = 2;
                if (ce && ge && win == 1) m_cnt++;
                if (win == 2) m_cnt = 0;
                if (cerr || gerr) m_err = 1;
            end
            src = (m_owner != 0) ? m_owner : win;
            ev  = 0;
            ed  = '0;
            eg  = 2'b00;
            if (src == 1) begin
                ev = cast_valid_i;   ed = cast_data_i;   eg = 2'b01;
            end else if (src == 2) begin
                ev = gather_valid_i; ed = gather_data_i; eg = 2'b10;
            end
            ecr = (src == 1) ? cr : cerr;
            egr = (src == 2) ? cr : gerr;
            chk("cast_ready_o", 32'(cast_ready_o), 32'(ecr));
            chk("gather_ready_o", 32'(gather_ready_o), 32'(egr));
            chk("grant_o", 32'(grant_o), 32'(eg));
            if (src != 0) begin
                if (ev && cr && (ed[31:30] == 2'b10 || ed[31:30] == 2'b11)) m_owner = 0;
                else m_owner = src;
            end
`ifdef CG_ARB_SKID_EN
            outv = (m_q.size() != 0);
            chk("valid_o", 32'(cast_gather_valid_o), 32'(outv));
            if (outv) chk("data_o", cast_gather_data_o, m_q[0]);
            if (outv && cast_gather_ready_i) void'(m_q.pop_front());
            if (ev && cr) m_q.push_back(ed);
`else
            outv = ev;
            chk("valid_o", 32'(cast_gather_valid_o), 32'(outv));
            if (outv) chk("data_o", cast_gather_data_o, ed);
`endif
        end
    end

    // Source drivers: per-source flit queues, valid held until accepted
    logic [31:0] cq[$];
    logic [31:0] gq[$];
    int          gap_pct  = 0;
    int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit          cx = 0, gx = 0;
    string       hist = "";
    int          seq = 0;

    task automatic drive();
        if (cq.size() > 0) begin
            if (!cast_valid_i || cx) cast_valid_i = ($urandom_range(99) >= gap_pct);
            cast_data_i = cq[0];
        end else cast_valid_i = 1'b0;
        if (gq.size() > 0) begin
            if (!gather_valid_i || gx) gather_valid_i = ($urandom_range(99) >= gap_pct);
            gather_data_i = gq[0];
        end else gather_valid_i = 1'b0;
        case (rdy_mode)
            0:       cast_gather_ready_i = ($urandom_range(99) >= 25);
            1:       cast_gather_ready_i = 1'b1;
            default: cast_gather_ready_i = 1'b0;
        endcase
    endtask

    task automatic sample();
        @(negedge clk);
        cx = cast_valid_i && cast_ready_o;
        gx = gather_valid_i && gather_ready_o;
        if (cx && (cast_data_i[31:30] == 2'b00 || cast_data_i[31:30] == 2'b11)) hist = {hist, "C"};
        if (gx && (gather_data_i[31:30] == 2'b00 || gather_data_i[31:30] == 2'b11)) hist = {hist, "G"};
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (cx && cq.size() > 0) void'(cq.pop_front());
        if (gx && gq.size() > 0) void'(gq.pop_front());
        drive();
    endtask

    task automatic add_pkt(input bit to_gather, input int len);
        logic [31:0] f;
        for (int i = 0; i < len; i++) begin
            seq++;
            f[29:0]  = 30'(seq);
            f[31:30] = (len == 1) ? 2'b11 : (i == 0) ? 2'b00 : (i == len - 1) ? 2'b10 : 2'b01;
            if (to_gather) gq.push_back(f); else cq.push_back(f);
        end
    endtask

    task automatic run_until_empty(input string name, input int bound);
        int n = 0;
        while ((cq.size() > 0 || gq.size() > 0) && n < bound) begin
            sample();
            advance();
            n++;
        end
        checks++;
        if (cq.size() > 0 || gq.size() > 0) begin
            errors++;
            $display("FAIL %s timeout: %0d cast and %0d gather flits left, required 0", name, cq.size(), gq.size());
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cq.delete();
        gq.delete();
        drive();
        sample();
        advance();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        cast_valid_i = 1'b0; gather_valid_i = 1'b0;
        cast_data_i = '0;    gather_data_i = '0;
        cast_gather_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        drive();
        sample();
        chk("reset_grant", 32'(grant_o), 0);
        chk("reset_valid", 32'(cast_gather_valid_o), 0);
        chk("reset_err", 32'(err_o), 0);
        advance();

        // T1: lone cast single flit
        cq.push_back(32'hC000_0001);
        drive();
        sample();
        chk("t1_grant", 32'(grant_o), 32'h1);
`ifndef CG_ARB_SKID_EN
        chk("t1_valid", 32'(cast_gather_valid_o), 1);
        chk("t1_data", cast_gather_data_o, 32'hC000_0001);
`endif
        advance();
        sample();
`ifdef CG_ARB_SKID_EN
        chk("t1_valid", 32'(cast_gather_valid_o), 1);
        chk("t1_data", cast_gather_data_o, 32'hC000_0001);
`endif
        chk("t1_grant_idle", 32'(grant_o), 0);
        advance();

        // T5: stray gather body flit while idle
        gq.push_back(32'h4000_0005);
        drive();
        sample();
        chk("t5_gather_ready", 32'(gather_ready_o), 1);
        chk("t5_valid", 32'(cast_gather_valid_o), 0);
        advance();
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t5_err_sticky", 32'(err_o), 1);
            advance();
        end
        do_reset();

        // T3: continuous contention, weight 2
        hist = "";
        for (int i = 0; i < 4; i++) begin
            add_pkt(1'b0, 3);
            add_pkt(1'b1, 3);
        end
        drive();
        run_until_empty("t3_drain", 200);
        checks++;
        if (hist != "CCGCCGGG") begin
            errors++;
            $display("FAIL t3_grant_order: got %s expected CCGCCGGG", hist);
        end

        // T2: gather head arrives during a cast packet
        hist = "";
        add_pkt(1'b0, 4);
        drive();
        sample();
        advance();
        add_pkt(1'b1, 2);
        drive();
        for (int i = 0; i < 3; i++) begin
            sample();
            if (cq.size() > 0) chk("t2_gather_blocked", 32'(gather_ready_o), 0);
            advance();
        end
        run_until_empty("t2_drain", 50);
        checks++;
        if (hist != "CG") begin
            errors++;
            $display("FAIL t2_order: got %s expected CG", hist);
        end

        // T4: downstream stall on cast head with gather requesting
        cq.push_back(32'h0000_0A01); cq.push_back(32'h4000_0A02);
        cq.push_back(32'h4000_0A03); cq.push_back(32'h8000_0A04);
        gq.push_back(32'hC000_0B01);
        rdy_mode = 2;
        drive();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t4_grant", 32'(grant_o), 32'h1);
            if (i >= 1) begin
                chk("t4_valid", 32'(cast_gather_valid_o), 1);
                chk("t4_data", cast_gather_data_o, 32'h0000_0A01);
            end
            advance();
        end
        rdy_mode = 1;
        drive();
        run_until_empty("t4_drain", 50);

        // T6: reset in the middle of a cast packet
        add_pkt(1'b0, 4);
        drive();
        for (int i = 0; i < 2; i++) begin
            sample();
            advance();
        end
        do_reset();
        sample();
        chk("t6_grant", 32'(grant_o), 0);
        chk("t6_valid", 32'(cast_gather_valid_o), 0);
        advance();
        hist = "";
        add_pkt(1'b1, 2);
        drive();
        run_until_empty("t6_drain", 50);
        checks++;
        if (hist != "G") begin
            errors++;
            $display("FAIL t6_rearb: got %s expected G", hist);
        end

        // Random traffic with stalls, gaps, stray flits and periodic resets
        gap_pct  = 30;
        rdy_mode = 0;
        for (int seg = 0; seg < 4; seg++) begin
            for (int n = 0; n < 800; n++) begin
                if (cq.size() < 3) begin
                    if ($urandom_range(99) < 3) cq.push_back({2'($urandom_range(1, 2)), 30'(n)});
                    else add_pkt(1'b0, $urandom_range(1, 4));
                end
                if (gq.size() < 3) begin
                    if ($urandom_range(99) < 3) gq.push_back({2'($urandom_range(1, 2)), 30'(n)});
                    else add_pkt(1'b1, $urandom_range(1, 4));
                end
                drive();
                sample();
                advance();
            end
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
